// File: rtl/column_input_conditioner_pkg.sv
// Shared Connect-4 definitions: active-low column codes, game status encoding
// and the state encoding of the column input conditioner.
package connect4_pkg;

  localparam logic [3:0] COL_NONE = 4'b1111;
  localparam logic [3:0] COL0     = 4'b1110;
  localparam logic [3:0] COL1     = 4'b1101;
  localparam logic [3:0] COL2     = 4'b1011;
  localparam logic [3:0] COL3     = 4'b0111;

  localparam logic [1:0] GAME_PLAYING = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_RELEASE = 2'd1,
    ST_LOCKED       = 2'd2
  } cic_state_e;

  // True when exactly one column button is held (a legal move).
  function automatic logic is_single_press(input logic [3:0] v);
    return (v == COL0) || (v == COL1) || (v == COL2) || (v == COL3);
  endfunction

endpackage

// File: rtl/column_input_conditioner_if.sv
// Button/game-status inputs and column/pulse outputs of the column conditioner.
interface column_input_conditioner_if;

  logic [3:0] btn_n;
  logic [1:0] game_status;
  logic [3:0] out_column;
  logic       out_enable;
  logic       out_error;

  modport master (
    output btn_n,
    output game_status,
    input  out_column,
    input  out_enable,
    input  out_error
  );

  modport slave (
    input  btn_n,
    input  game_status,
    output out_column,
    output out_enable,
    output out_error
  );

endinterface

// File: rtl/column_input_conditioner_debounce_filter.sv
// Synchronizes the raw button vector and accepts a new value only after it has
// stayed unchanged long enough; pulses o_stable_changed when it is accepted.
module debounce_filter
  import connect4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_btn_n,
  output logic [3:0] o_stable,
  output logic       o_stable_changed
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [3:0]                  w_sync;
  logic [3:0]                  r_candidate;
  logic [CNT_W-1:0]            r_count;
  logic [3:0]                  r_stable;
  logic                        r_stable_changed;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Stage 0 holds the newest sample; reset to released so no phantom press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= {SYNC_STAGES{COL_NONE}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_n};
    end
  end

  // The counter is cleared on acceptance, so it stops at CNT_LAST and never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_candidate      <= COL_NONE;
      r_count          <= '0;
      r_stable         <= COL_NONE;
      r_stable_changed <= 1'b0;
    end else begin
      r_stable_changed <= 1'b0;
      if (w_sync != r_candidate) begin
        r_candidate <= w_sync;
        r_count     <= '0;
      end else if (r_candidate != r_stable) begin
        if (r_count == CNT_LAST) begin
          r_stable         <= r_candidate;
          r_count          <= '0;
          r_stable_changed <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign o_stable         = r_stable;
  assign o_stable_changed = r_stable_changed;

endmodule

// File: rtl/column_input_conditioner.sv
// Connect-4 column button conditioner: debounced vector in, held one-hot column
// code plus one-clock accept/reject pulses out, gated by the game status.
module column_input_conditioner
  import connect4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input logic                       clk,
  input logic                       reset,
  column_input_conditioner_if.slave bus
);

  logic [3:0] w_stable;
  logic       w_stable_changed;
  cic_state_e r_state;
  cic_state_e w_state_nxt;
  logic [3:0] r_column;
  logic [3:0] w_column_nxt;
  logic       r_enable;
  logic       w_enable_nxt;
  logic       r_error;
  logic       w_error_nxt;

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_debounce (
    .clk              (clk),
    .reset            (reset),
    .i_btn_n          (bus.btn_n),
    .o_stable         (w_stable),
    .o_stable_changed (w_stable_changed)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_column <= COL_NONE;
      r_enable <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_column <= w_column_nxt;
      r_enable <= w_enable_nxt;
      r_error  <= w_error_nxt;
    end
  end

  // Game-over lockout overrides everything, including a press decided this cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_column_nxt = r_column;
    w_enable_nxt = 1'b0;
    w_error_nxt  = 1'b0;
    if (bus.game_status != GAME_PLAYING) begin
      w_state_nxt = ST_LOCKED;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_stable_changed && (w_stable != COL_NONE)) begin
            if (is_single_press(w_stable)) begin
              w_enable_nxt = 1'b1;
              w_column_nxt = w_stable;
            end else begin
              w_error_nxt = 1'b1;
            end
            w_state_nxt = ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (w_stable == COL_NONE) w_state_nxt = ST_IDLE;
        end
        ST_LOCKED: begin
          if (w_stable == COL_NONE) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.out_column = r_column;
  assign bus.out_enable = r_enable;
  assign bus.out_error  = r_error;

endmodule

// File: tb/tb_column_input_conditioner.sv
// Directed and randomized bench for column_input_conditioner, compared every
// clock against a window-based behavioural model of debounce and press rules.
module tb_column_input_conditioner;

  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;

  column_input_conditioner_if ifc ();

  column_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int    passed = 0;
  int    total  = 0;
  int    cyc    = 0;
  string phase  = "init";
  int    ph_en, ph_err, ph_lat;

  // Model: raw sample history, accepted vector, press mode (0 idle, 1 wait release, 2 locked).
  logic [3:0] hist[$];
  logic [3:0] m_stable;
  logic       m_chg;
  int         m_mode;
  logic [3:0] m_col;
  logic       m_en, m_err;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= S + D; i++) hist.push_back(4'hF);
    m_stable = 4'hF;
    m_chg    = 1'b0;
    m_mode   = 0;
    m_col    = 4'hF;
    m_en     = 1'b0;
    m_err    = 1'b0;
  endtask

  // One clock edge: press rules act on the vector accepted at the previous edge;
  // a vector is accepted once D+1 consecutive synchronized samples agree.
  task automatic model_edge(input logic [3:0] raw, input logic [1:0] gs);
    logic [3:0] v;
    bit         run_ok;
    m_en  = 1'b0;
    m_err = 1'b0;
    if (gs != 2'b00) begin
      m_mode = 2;
    end else if (m_mode == 0) begin
      if (m_chg && m_stable != 4'hF) begin
        if ($countones(~m_stable) == 1) begin
          m_en  = 1'b1;
          m_col = m_stable;
        end else begin
          m_err = 1'b1;
        end
        m_mode = 1;
      end
    end else if (m_stable == 4'hF) begin
      m_mode = 0;
    end
    hist.push_front(raw);
    void'(hist.pop_back());
    v      = hist[S];
    run_ok = 1'b1;
    for (int i = S; i <= S + D; i++) if (hist[i] != v) run_ok = 1'b0;
    m_chg = 1'b0;
    if (run_ok && v != m_stable) begin
      m_stable = v;
      m_chg    = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge(ifc.btn_n, ifc.game_status);
    #1;
    check($sformatf("%s enable c%0d", phase, cyc), {3'b000, ifc.out_enable}, {3'b000, m_en});
    check($sformatf("%s error c%0d", phase, cyc), {3'b000, ifc.out_error}, {3'b000, m_err});
    check($sformatf("%s column c%0d", phase, cyc), ifc.out_column, m_col);
    cyc++;
  endtask

  task automatic run(input int n);
    ph_en  = 0;
    ph_err = 0;
    ph_lat = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ifc.out_enable === 1'b1) begin
        if (ph_lat < 0) ph_lat = i;
        ph_en++;
      end
      if (ifc.out_error === 1'b1) ph_err++;
    end
  endtask

  task automatic async_reset(input string tag, input int hold);
    reset = 1'b0;
    model_reset();
    #1;
    check({tag, " rst column"}, ifc.out_column, 4'b1111);
    check({tag, " rst enable"}, {3'b000, ifc.out_enable}, 4'b0000);
    check({tag, " rst error"}, {3'b000, ifc.out_error}, 4'b0000);
    run(hold);
    reset = 1'b1;
  endtask

  initial begin
    reset           = 1'b1;
    ifc.btn_n       = 4'hF;
    ifc.game_status = 2'b00;
    model_reset();
    #2;
    phase = "reset";
    async_reset("reset", 3);
    run(50);
    check_int("reset idle enables", ph_en, 0);
    check_int("reset idle errors", ph_err, 0);
    check("reset idle column", ifc.out_column, 4'b1111);

    phase     = "clean";
    ifc.btn_n = 4'b1101;
    run(20);
    check_int("clean latency", ph_lat, 7);
    check_int("clean enables", ph_en, 1);
    ifc.btn_n = 4'hF;
    run(20);
    check_int("clean release enables", ph_en, 0);
    check("clean held column", ifc.out_column, 4'b1101);

    phase = "bounce";
    for (int k = 0; k < 6; k++) begin
      ifc.btn_n = (k % 2 == 0) ? 4'b1110 : 4'b1111;
      run(2);
      check_int($sformatf("bounce toggle %0d pulses", k), ph_en + ph_err, 0);
    end
    ifc.btn_n = 4'b1110;
    run(20);
    check_int("bounce settled enables", ph_en, 1);
    check("bounce column", ifc.out_column, 4'b1110);
    ifc.btn_n = 4'hF;
    run(20);

    phase     = "multi";
    ifc.btn_n = 4'b1010;
    run(20);
    check_int("multi errors", ph_err, 1);
    check_int("multi enables", ph_en, 0);
    check("multi column kept", ifc.out_column, 4'b1110);
    ifc.btn_n = 4'b1011;
    run(20);
    check_int("multi narrowed pulses", ph_en + ph_err, 0);
    ifc.btn_n = 4'hF;
    run(20);
    ifc.btn_n = 4'b1011;
    run(20);
    check_int("multi repress enables", ph_en, 1);
    check("multi repress column", ifc.out_column, 4'b1011);
    ifc.btn_n = 4'hF;
    run(20);

    phase           = "lock";
    ifc.game_status = 2'b01;
    ifc.btn_n       = 4'b0111;
    run(20);
    check_int("lock over pulses", ph_en + ph_err, 0);
    ifc.game_status = 2'b00;
    run(20);
    check_int("lock restart held pulses", ph_en + ph_err, 0);
    ifc.btn_n = 4'hF;
    run(20);
    ifc.btn_n = 4'b0111;
    run(20);
    check_int("lock repress enables", ph_en, 1);
    check("lock repress column", ifc.out_column, 4'b0111);
    ifc.btn_n = 4'hF;
    run(20);

    phase     = "midreset";
    ifc.btn_n = 4'b1110;
    run(2);
    async_reset("midreset", 2);
    run(20);
    check_int("midreset latency", ph_lat, 7);
    check_int("midreset enables", ph_en, 1);
    check("midreset column", ifc.out_column, 4'b1110);
    ifc.btn_n = 4'hF;
    run(20);

    phase = "random";
    for (int blk = 0; blk < 150; blk++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 6) ifc.btn_n = 4'hF;
      else if (r < 12) ifc.btn_n = 4'hF ^ 4'(1 << $urandom_range(0, 3));
      else ifc.btn_n = 4'($urandom);
      ifc.game_status = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 39) == 0) async_reset("random", 1);
      run($urandom_range(1, 12));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/column_input_conditioner.md
# column_input_conditioner

Conditions the four raw active-low column push-buttons of the Connect-4 board and feeds the column-select FSM. It produces a held, active-low one-hot column code plus a one-clock enable pulse per accepted press. It synchronizes and debounces the buttons, rejects multi-button presses, enforces press/release alternation, and blocks input while the game is over.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable clocks required before a button vector is accepted (minimum 2).
- SYNC_STAGES, default 2: synchronizer flip-flop depth per button (minimum 2).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- btn_n  in  4  raw asynchronous buttons, active-low; bit i = column i.
- game_status  in  2  from column-select FSM; 2'b00 = game in play, any other value = game over.
- out_column  out  4  active-low one-hot column (1110 = col 0, 1101 = col 1, 1011 = col 2, 0111 = col 3); drives FSM in_column.
- out_enable  out  1  one-clock pulse, column accepted; drives FSM enable.
- out_error  out  1  one-clock pulse, multi-button press rejected.

## Operation
- Synchronizer: SYNC_STAGES flops per bit; all stages reset to 1.
- Debounce on the whole 4-bit vector. The block keeps a candidate register (reset 4'b1111), a counter (reset 0) and a stable register (reset 4'b1111).
  - Synchronized vector differs from candidate: load candidate, clear counter.
  - Vector equals candidate and differs from stable: increment counter. When the counter reaches DEBOUNCE_CYCLES-1, copy candidate into stable and clear the counter.
  - Counter saturates and never wraps.
- FSM has states IDLE, WAIT_RELEASE and LOCKED; reset state is IDLE.
  - IDLE, stable changes to exactly one zero bit: pulse out_enable, load out_column with stable, go to WAIT_RELEASE.
  - IDLE, stable changes to two or more zero bits: pulse out_error, leave out_column unchanged, go to WAIT_RELEASE.
  - WAIT_RELEASE, stable == 4'b1111: go to IDLE. Any other stable change, including an added button, is ignored.
  - Any state, game_status != 2'b00: go to LOCKED. No enable or error pulse is issued in the same cycle. This rule has priority over every other transition.
  - LOCKED, game_status == 2'b00 and stable == 4'b1111: go to IDLE. If a button is still held when the game restarts, the block stays LOCKED until release.
- out_column holds the last accepted code until the next accepted press.
- Reset values: out_column = 4'b1111, out_enable = 0, out_error = 0.
- out_enable and out_error are mutually exclusive.

## Timing
- All outputs are registered.
- Latency: a clean raw press held from before clock edge 0 produces out_enable high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1. With the defaults this is edge 19.
- out_column takes its new value on the same edge that out_enable rises. It is valid whenever out_enable = 1.
- A glitch shorter than DEBOUNCE_CYCLES clocks never changes stable and produces no pulse.
- Maximum acceptance rate is one press per press/release cycle, i.e. at least 2·(DEBOUNCE_CYCLES+1) clocks apart.
- Reset asserted mid-operation:
  - all registers return to reset values immediately (asynchronous);
  - any pulse in flight is cancelled;
  - after reset is released, a button still held is accepted once it has debounced, because candidate/stable restart at 1111.
- game_status is sampled directly; no synchronizer is needed because it comes from the same clock domain.

## Structure
- Shared package connect4_pkg holds:
  - COL_NONE = 4'b1111 and COL0..COL3 active-low codes;
  - GAME_PLAYING = 2'b00;
  - the state encoding of this block.
- Sub-module debounce_filter holds the parameterized vector synchronizer plus candidate/counter/stable logic. It outputs the stable vector and a one-cycle stable_changed strobe.
- The top level holds the FSM and output registers.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
- Reset: reset=0 -> out_column=1111, out_enable=0, out_error=0. Release reset with btn_n=1111 -> outputs unchanged for 50 clocks.
- Clean press: btn_n=1101 held 20 clocks, then 1111 -> exactly one out_enable pulse, 7 edges after the press. out_column=1101 holds after release. No second pulse on release.
- Bounce: btn_n toggles 1110/1111 every 2 clocks for 12 clocks, then settles at 1110 -> no pulse during the toggling; one out_enable pulse with out_column=1110 after settling.
- Multi-press and hold: btn_n=1010 -> one out_error pulse, no enable, out_column unchanged. Change btn_n to 1011 without full release -> no pulse. Release, then press 1011 -> enable pulse.
- Lockout: game_status=01 with btn_n=0111 pressed -> no pulses. Set game_status=00 while still held -> no pulse. Release, then press 0111 -> enable pulse with out_column=0111.
- Reset mid-debounce: assert reset 2 clocks after btn_n=1110 is applied and keep the button held -> outputs go to reset values at once. After release of reset, one enable pulse follows 7 edges later.
